// File: rtl/cic_interp_pkg.sv
// ============================================================================
// cic_interp_pkg : shared helpers for the CIC interpolator comb/integrator halves
// Revision 1.0
// ============================================================================
`default_nettype none

package cic_interp_pkg;

   // Register growth of an N-stage, unit-delay CIC interpolator: ceil(log2(R^N / R)).
   function automatic int cic_interp_growth(input int num_stages, input int rate);
      longint gain;
      gain = 1;
      for (int k = 1; k < num_stages; k++) begin
         gain = gain * longint'(rate);
      end
      return $clog2(gain);
   endfunction

endpackage

`default_nettype wire

// File: rtl/cic_interp_integ_stage.sv
// ============================================================================
// cic_interp_integ_stage : one I/Q integrator with enable and valid tracking
// Revision 1.0
// ============================================================================
`default_nettype none

module cic_interp_integ_stage
   import cic_interp_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_inph,
   input  logic [WIDTH-1:0] i_quad,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_inph,
   output logic [WIDTH-1:0] o_quad
);

   logic             valid_d, valid_q;
   logic [WIDTH-1:0] inph_d, inph_q;
   logic [WIDTH-1:0] quad_d, quad_q;

   // Accumulators only move on a valid slot; bubbles leave them untouched.
   always_comb begin
      valid_d = valid_q;
      inph_d  = inph_q;
      quad_d  = quad_q;
      if (i_en) begin
         valid_d = i_valid;
         if (i_valid) begin
            inph_d = inph_q + i_inph;
            quad_d = quad_q + i_quad;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         valid_q <= 1'b0;
         inph_q  <= '0;
         quad_q  <= '0;
      end else begin
         valid_q <= valid_d;
         inph_q  <= inph_d;
         quad_q  <= quad_d;
      end
   end

   assign o_valid = valid_q;
   assign o_inph  = inph_q;
   assign o_quad  = quad_q;

endmodule

`default_nettype wire

// File: rtl/cic_interp_integ_upsample.sv
// ============================================================================
// cic_interp_integ_upsample : zero-stuffing upsampler plus pipelined integrators
// Revision 1.0
// ============================================================================
`default_nettype none

module cic_interp_integ_upsample
   import cic_interp_pkg::*;
#(
   parameter int IN_WIDTH   = 16,
   parameter int OUT_WIDTH  = 32,
   parameter int NUM_STAGES = 3,
   parameter int RATE       = 8
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic [IN_WIDTH-1:0]  i_inph_data,
   input  logic [IN_WIDTH-1:0]  i_quad_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic [OUT_WIDTH-1:0] o_inph_data,
   output logic [OUT_WIDTH-1:0] o_quad_data,
   output logic                 o_valid,
   input  logic                 i_ready
);

   localparam int PHASE_W = $clog2(RATE);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(RATE - 1);

   logic               en;
   logic               inject;
   logic [PHASE_W-1:0] phase_d, phase_q;

   logic                 valid_c [0:NUM_STAGES];
   logic [OUT_WIDTH-1:0] inph_c  [0:NUM_STAGES];
   logic [OUT_WIDTH-1:0] quad_c  [0:NUM_STAGES];

   // The whole pipeline advances together, so a stalled output freezes every stage.
   always_comb begin
      en      = !o_valid || i_ready;
      inject  = en && ((phase_q != '0) || i_valid);
      phase_d = phase_q;
      if (inject) begin
         phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign o_ready    = en && (phase_q == '0);
   assign valid_c[0] = inject;
   assign inph_c[0]  = (phase_q == '0) ? OUT_WIDTH'($signed(i_inph_data)) : '0;
   assign quad_c[0]  = (phase_q == '0) ? OUT_WIDTH'($signed(i_quad_data)) : '0;

   generate
      for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_stage
         cic_interp_integ_stage #(
            .WIDTH (OUT_WIDTH)
         ) u_stage (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_en    (en),
            .i_valid (valid_c[k-1]),
            .i_inph  (inph_c[k-1]),
            .i_quad  (quad_c[k-1]),
            .o_valid (valid_c[k]),
            .o_inph  (inph_c[k]),
            .o_quad  (quad_c[k])
         );
      end
   endgenerate

   assign o_valid     = valid_c[NUM_STAGES];
   assign o_inph_data = inph_c[NUM_STAGES];
   assign o_quad_data = quad_c[NUM_STAGES];

endmodule

`default_nettype wire

// File: tb/tb_cic_interp_integ_upsample.sv
// ============================================================================
// tb_cic_interp_integ_upsample : random handshake stimulus against an N-fold cumulative-sum model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cic_interp_integ_upsample;

   // Output narrower than full growth so modulo wrap-around is exercised.
   localparam int IW = 16;
   localparam int OW = 20;
   localparam int NS = 3;
   localparam int RT = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [IW-1:0] in_i = '0;
   logic [IW-1:0] in_q = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [OW-1:0] out_i;
   logic [OW-1:0] out_q;
   logic          out_valid;
   logic          out_ready = 1'b1;

   cic_interp_integ_upsample #(
      .IN_WIDTH   (IW),
      .OUT_WIDTH  (OW),
      .NUM_STAGES (NS),
      .RATE       (RT)
   ) u_dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_inph_data (in_i),
      .i_quad_data (in_q),
      .i_valid     (in_valid),
      .o_ready     (in_ready),
      .o_inph_data (out_i),
      .o_quad_data (out_q),
      .o_valid     (out_valid),
      .i_ready     (out_ready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Model: expected output stream is the NS-times cumulative sum of the zero-stuffed input.
   logic [OW-1:0] sum_i [NS];
   logic [OW-1:0] sum_q [NS];
   logic [OW-1:0] exp_i [$];
   logic [OW-1:0] exp_q [$];

   function automatic void model_reset();
      for (int k = 0; k < NS; k++) begin
         sum_i[k] = '0;
         sum_q[k] = '0;
      end
      exp_i.delete();
      exp_q.delete();
   endfunction

   function automatic void model_push(input logic [IW-1:0] si, input logic [IW-1:0] sq);
      logic [OW-1:0] ui, uq;
      for (int r = 0; r < RT; r++) begin
         ui = (r == 0) ? OW'($signed(si)) : '0;
         uq = (r == 0) ? OW'($signed(sq)) : '0;
         for (int k = 0; k < NS; k++) begin
            sum_i[k] = sum_i[k] + ui;
            sum_q[k] = sum_q[k] + uq;
            ui = sum_i[k];
            uq = sum_q[k];
         end
         exp_i.push_back(ui);
         exp_q.push_back(uq);
      end
   endfunction

   // One clock: observe handshakes at the falling edge, update the model after the rising edge.
   task automatic cycle();
      logic          acc, hs, stall;
      logic [IW-1:0] si, sq;
      logic [OW-1:0] hi, hq;
      @(negedge clk);
      acc   = in_valid && in_ready;
      hs    = out_valid && out_ready;
      stall = out_valid && !out_ready;
      si = in_i;
      sq = in_q;
      hi = out_i;
      hq = out_q;
      if (hs) begin
         if (exp_i.size() == 0) begin
            check("extra_output", 64'(exp_i.size()), 64'd1);
         end else begin
            check("out_inph", 64'(hi), 64'(exp_i.pop_front()));
            check("out_quad", 64'(hq), 64'(exp_q.pop_front()));
         end
      end
      if (stall) check("stall_o_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      if (acc) model_push(si, sq);
      if (stall) begin
         check("stall_hold_valid", 64'(out_valid), 64'd1);
         check("stall_hold_inph", 64'(out_i), 64'(hi));
         check("stall_hold_quad", 64'(out_q), 64'(hq));
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check("rst_o_valid", 64'(out_valid), 64'd0);
      check("rst_o_inph", 64'(out_i), 64'd0);
      check("rst_o_quad", 64'(out_q), 64'd0);
      check("rst_o_ready", 64'(in_ready), 64'd1);
   endtask

   // Impulse on I: first output appears NS-1 edges after the accepting edge.
   task automatic impulse_test();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_i      = 16'd1;
      in_q      = '0;
      cycle();
      in_valid = 1'b0;
      in_i     = '0;
      for (int d = 0; d < NS - 1; d++) begin
         check("lat_no_valid", 64'(out_valid), 64'd0);
         cycle();
      end
      check("lat_valid", 64'(out_valid), 64'd1);
      check("lat_first_inph", 64'(out_i), 64'd1);
      check("lat_first_quad", 64'(out_q), 64'd0);
      for (int c = 0; c < 3 * RT; c++) cycle();
   endtask

   task automatic random_phase(input int cycles);
      int stall_left;
      stall_left = 0;
      for (int c = 0; c < cycles; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_i     = IW'($urandom);
         in_q     = IW'($urandom);
         if (stall_left > 0) begin
            stall_left--;
            out_ready = 1'b0;
         end else if ($urandom_range(0, 60) == 0) begin
            stall_left = 4;
            out_ready  = 1'b0;
         end else begin
            out_ready = ($urandom_range(0, 4) != 0);
         end
         cycle();
      end
   endtask

   task automatic drain();
      int budget;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      budget    = 0;
      while (exp_i.size() != 0 && budget < 200) begin
         cycle();
         budget++;
      end
      check("drain_empty", 64'(exp_i.size()), 64'd0);
      cycle();
      check("drain_idle_valid", 64'(out_valid), 64'd0);
   endtask

   initial begin
      model_reset();
      do_reset();
      impulse_test();
      random_phase(1200);
      drain();
      // Reset while data is in flight, then confirm the impulse reproduces exactly.
      random_phase(37);
      do_reset();
      impulse_test();
      random_phase(1200);
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
